// File: rtl/clkgen_pkg.sv
// Shared constants for the clock generator: voltage scaling, gate thresholds, CV clamps.
// Pulse-width CV decoding in clkgen is enabled by defining CLKGEN_PW_CV_EN.
package clkgen_pkg;

  // Samples are millivolts x4.
  localparam int FROM_MV = 4;

  localparam logic signed [15:0] SCHMITT_HI = 16'(2000 * FROM_MV);
  localparam logic signed [15:0] SCHMITT_LO = 16'(500 * FROM_MV);
  localparam logic signed [15:0] OUT_LO     = 16'sd0;

  localparam int MIN_PERIOD = 4000;

  localparam logic signed [15:0] CV_MIN = 16'sd0;
  localparam logic signed [15:0] CV_MAX = 16'(5000 * FROM_MV);

  // Duty-cycle eighths decoded from the pulse-width CV.
  localparam int PW_SHIFT = 11;
  localparam logic signed [15:0] PW_LO_RAW = 16'sd2048;   // below: d would be < 1
  localparam logic signed [15:0] PW_HI_RAW = 16'sd16384;  // at/above: d would be > 7

  typedef struct packed {
    logic [14:0] period;
    logic [14:0] width;
  } cycle_t;

endpackage

// File: rtl/clkgen_schmitt_trigger.sv
// Hysteresis gate detector; level reflects the current sample, rise pulses on a strobed 0->1.
module schmitt_trigger
  import clkgen_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               strobe,
  input  logic signed [15:0] sample,
  output logic               level,
  output logic               rise
);

  logic state;

  always_comb begin
    level = state;
    if (sample > SCHMITT_HI)      level = 1'b1;
    else if (sample < SCHMITT_LO) level = 1'b0;
  end

  assign rise = strobe & level & ~state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      state <= 1'b0;
    else if (strobe) state <= level;
  end

endmodule

// File: rtl/clkgen.sv
// Tempo-CV clock generator with /2, /4 and downbeat outputs, re-sync and run gates.
// Define CLKGEN_PW_CV_EN to take the pulse width from sample_in1 instead of a fixed 50% duty.
module clkgen
  import clkgen_pkg::*;
#(
  parameter int MAX_PERIOD = 24000,
  parameter int OUT_HI_RAW = 20000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               sample_strobe,
  input  logic signed [15:0] sample_in0,
  input  logic signed [15:0] sample_in1,
  input  logic signed [15:0] sample_in2,
  input  logic signed [15:0] sample_in3,
  output logic signed [15:0] sample_out0,
  output logic signed [15:0] sample_out1,
  output logic signed [15:0] sample_out2,
  output logic signed [15:0] sample_out3
);

  localparam logic signed [15:0] OUT_HI = 16'(OUT_HI_RAW);

  // Gate lane 0 is re-sync, lane 1 is run.
  logic [1:0][15:0] gate_in;
  logic [1:0]       gate_lvl, gate_rise;

  assign gate_in = {sample_in3, sample_in2};

  for (genvar g = 0; g < 2; g++) begin : g_gate
    schmitt_trigger u_st (
      .clk    (clk),
      .rst_n  (rst_n),
      .strobe (sample_strobe),
      .sample (gate_in[g]),
      .level  (gate_lvl[g]),
      .rise   (gate_rise[g])
    );
  end

  logic run_lvl, run_rise, sync_rise, sync_unused;
  assign run_lvl     = gate_lvl[1];
  assign run_rise    = gate_rise[1];
  assign sync_rise   = gate_rise[0];
  assign sync_unused = gate_lvl[0];

  logic [14:0] cv_mag, period_cv, width_cv;

  always_comb begin
    if (sample_in0 < CV_MIN)      cv_mag = '0;
    else if (sample_in0 > CV_MAX) cv_mag = CV_MAX[14:0];
    else                          cv_mag = sample_in0[14:0];
  end

  assign period_cv = 15'(MAX_PERIOD) - cv_mag;

`ifdef CLKGEN_PW_CV_EN
  logic [2:0] pw_d;

  always_comb begin
    if (sample_in1 < PW_LO_RAW)       pw_d = 3'd1;
    else if (sample_in1 >= PW_HI_RAW) pw_d = 3'd7;
    else                              pw_d = sample_in1[PW_SHIFT+2:PW_SHIFT];
  end

  assign width_cv = 15'((18'(period_cv) * 18'(pw_d)) >> 3);
`else
  logic pw_unused;
  assign pw_unused = ^sample_in1;
  assign width_cv  = period_cv >> 1;
`endif

  cycle_t      cyc, cyc_nxt;
  logic [14:0] phase, phase_nxt;
  logic [2:0]  beat, beat_nxt;
  logic        wrap, main_hi;

  always_comb begin
    wrap      = (phase == cyc.period - 15'd1);
    phase_nxt = phase + 15'd1;
    beat_nxt  = beat;
    cyc_nxt   = cyc;
    // Re-sync beats the wrap increment when both land on one strobe.
    if (sync_rise)            beat_nxt = '0;
    else if (run_lvl && wrap) beat_nxt = beat + 3'd1;
    if (!run_lvl) begin
      phase_nxt = '0;
    end else if (sync_rise || run_rise || wrap) begin
      phase_nxt = '0;
      cyc_nxt   = '{period: period_cv, width: width_cv};
    end
  end

  assign main_hi = run_lvl && (phase_nxt < cyc_nxt.width);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase       <= '0;
      beat        <= '0;
      cyc         <= '{period: 15'(MAX_PERIOD), width: 15'(MAX_PERIOD >> 1)};
      sample_out0 <= OUT_LO;
      sample_out1 <= OUT_LO;
      sample_out2 <= OUT_LO;
      sample_out3 <= OUT_LO;
    end else if (sample_strobe) begin
      phase       <= phase_nxt;
      beat        <= beat_nxt;
      cyc         <= cyc_nxt;
      sample_out0 <= main_hi ? OUT_HI : OUT_LO;
      sample_out1 <= (run_lvl && !beat_nxt[0]) ? OUT_HI : OUT_LO;
      sample_out2 <= (run_lvl && !beat_nxt[1]) ? OUT_HI : OUT_LO;
      sample_out3 <= (main_hi && beat_nxt == 3'd0) ? OUT_HI : OUT_LO;
    end
  end

endmodule
